// File: rtl/dbus_scratchpad_responder.sv
// dbus_scratchpad_responder: fixed-latency 64-bit scratchpad on the data bus.
// Define DBUS_SCRATCHPAD_ERR_EN to enable range/alignment checks and the sticky err flag.
package dbus_pkg;
  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_scratchpad_responder
  import dbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, data_q, rdata_q, rdata_d;
  msize_t      size_q;
  logic [7:0]  strobe_q;
  logic        ok_q, err_q, err_d;
  logic [63:0] mem [DEPTH_WORDS];
  logic [63:0] c_addr, c_data;
  msize_t      c_size;
  logic [7:0]  c_strobe;
  logic        commit, bad;
  logic [AW-1:0] idx;
  // With zero latency the access commits on the accepting edge, so it must use the live request.
  assign c_addr   = state_q == IDLE ? dreq.addr   : addr_q;
  assign c_data   = state_q == IDLE ? dreq.data   : data_q;
  assign c_size   = state_q == IDLE ? dreq.size   : size_q;
  assign c_strobe = state_q == IDLE ? dreq.strobe : strobe_q;
  assign idx      = c_addr[AW+2:3];
`ifdef DBUS_SCRATCHPAD_ERR_EN
  assign bad = (c_addr >= 64'(DEPTH_WORDS * 8)) || ((c_addr & ((64'd1 << c_size) - 64'd1)) != 64'd0);
`else
  assign bad = 1'b0;
`endif
  logic unused_ok;
  assign unused_ok = ^{c_addr, c_size};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (dreq.valid) begin
        state_d = LATENCY == 0 ? RESP : WAIT;
        cnt_d   = 4'(LATENCY);
        commit  = LATENCY == 0;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!dreq.valid) state_d = IDLE;
        else if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rdata_d = commit ? ((c_strobe == 8'd0 && !bad) ? mem[idx] : 64'd0) : rdata_q;
    err_d   = err_q | (commit & bad);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 64'd0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ok_q    <= state_d == RESP;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == IDLE && dreq.valid) begin
      addr_q   <= dreq.addr;
      data_q   <= dreq.data;
      size_q   <= dreq.size;
      strobe_q <= dreq.strobe;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && commit && !bad)
      for (int i = 0; i < 8; i++)
        if (c_strobe[i]) mem[idx][8*i +: 8] <= c_data[8*i +: 8];
  end
  assign dresp.addr_ok = ok_q;
  assign dresp.data_ok = ok_q;
  assign dresp.data    = rdata_q;
  assign err           = err_q;
endmodule

// File: tb/tb_dbus_scratchpad_responder.sv
// tb_dbus_scratchpad_responder: random accesses against a word-array model, plus directed corner cases.
module tb_dbus_scratchpad_responder;
  import dbus_pkg::*;
  localparam int LAT = 2;
  localparam int DW = 16;
  logic clk = 0, reset = 0;
  dbus_req_t dreq, dreq1;
  dbus_resp_t dresp, dresp1;
  logic err, err1;
  logic [63:0] mem_m [DW];
  logic err_m = 0;
  int n_pass = 0, n_chk = 0;
  always #5 clk = ~clk;
  dbus_scratchpad_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .err(err));
  dbus_scratchpad_responder #(.DEPTH_WORDS(DW), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1), .err(err1));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask
  function automatic logic is_bad(input logic [63:0] a, input logic [2:0] sz);
`ifdef DBUS_SCRATCHPAD_ERR_EN
    return a >= 64'(DW * 8) || (a % (64'd1 << sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction
  task automatic access(input string tag, input logic [63:0] a, input logic [2:0] sz,
                        input logic [7:0] st, input logic [63:0] d, output logic [63:0] got);
    int n, w;
    logic e;
    logic [63:0] exp;
    w = int'((a / 8) % DW);
    e = is_bad(a, sz);
    exp = (st == 0 && !e) ? mem_m[w] : 64'd0;
    if (!e) for (int i = 0; i < 8; i++) if (st[i]) mem_m[w][8*i +: 8] = d[8*i +: 8];
    err_m = err_m | e;
    @(posedge clk); #1;
    dreq.valid = 1; dreq.addr = a; dreq.size = msize_t'(sz); dreq.strobe = st; dreq.data = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dresp.data_ok && n < 20);
    chk({tag, " latency"}, 64'(n), 64'(LAT + 1));
    chk({tag, " addr_ok"}, 64'(dresp.addr_ok), 64'd1);
    chk({tag, " data"}, dresp.data, exp);
    chk({tag, " err"}, 64'(err), 64'(err_m));
    got = dresp.data;
    dreq.valid = 0;
    dreq.addr = {$urandom, $urandom};
    @(posedge clk); #1;
    chk({tag, " pulse width"}, 64'(dresp.data_ok), 64'd0);
  endtask
  initial begin
    logic [63:0] g;
    dreq = '0; dreq1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset data_ok", 64'(dresp.data_ok), 64'd0);
    chk("reset addr_ok", 64'(dresp.addr_ok), 64'd0);
    chk("reset data", dresp.data, 64'd0);
    chk("reset err", 64'(err), 64'd0);
    reset = 1;
    for (int k = 0; k < DW; k++) begin
      mem_m[k] = 64'd0;
      access("init", 64'(k * 8), 3'd3, 8'hFF, {$urandom, $urandom}, g);
    end
    access("st full", 64'h10, 3'd3, 8'hFF, 64'h1122334455667788, g);
    access("ld full", 64'h10, 3'd3, 8'h00, 64'd0, g);
    chk("ld full value", g, 64'h1122334455667788);
    access("st part", 64'h10, 3'd3, 8'h0F, 64'hAAAAAAAABBBBBBBB, g);
    access("ld part", 64'h10, 3'd3, 8'h00, 64'd0, g);
    chk("ld part value", g, 64'h11223344BBBBBBBB);
    access("ld 0x14", 64'h14, 3'd3, 8'h00, 64'd0, g);
    access("ld after", 64'h18, 3'd3, 8'h00, 64'd0, g);
    @(posedge clk); #1;
    dreq1.valid = 1; dreq1.addr = 64'h8; dreq1.size = MSIZE8; dreq1.strobe = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b data_ok %0d", i), 64'(dresp1.data_ok), 64'(i % 2 == 0));
      chk($sformatf("b2b addr_ok %0d", i), 64'(dresp1.addr_ok), 64'(i % 2 == 0));
    end
    dreq1.valid = 0;
    @(posedge clk); #1;
    dreq.valid = 1; dreq.addr = 64'h30; dreq.size = MSIZE8; dreq.strobe = 8'hFF; dreq.data = 64'hDEADBEEFCAFEF00D;
    @(posedge clk); #1;
    dreq.valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort data_ok", 64'(dresp.data_ok), 64'd0);
    end
    access("ld abort", 64'h30, 3'd3, 8'h00, 64'd0, g);
    @(posedge clk); #1;
    dreq.valid = 1; dreq.addr = 64'h28; dreq.size = MSIZE8; dreq.strobe = 8'hFF; dreq.data = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    chk("rst wait data_ok", 64'(dresp.data_ok), 64'd0);
    chk("rst wait addr_ok", 64'(dresp.addr_ok), 64'd0);
    chk("rst wait data", dresp.data, 64'd0);
    chk("rst wait err", 64'(err), 64'd0);
    err_m = 0;
    dreq.valid = 0;
    reset = 1;
    access("ld rst", 64'h28, 3'd3, 8'h00, 64'd0, g);
    for (int k = 0; k < 60; k++) begin
      logic [7:0] st;
      st = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      access("rand", 64'($urandom_range(1023)), 3'($urandom_range(3)), st, {$urandom, $urandom}, g);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dbus_scratchpad_responder.md
# dbus_scratchpad_responder

Responder end of the core's data bus: accepts `dbus_req_t` requests from the memory stage, services them from an internal 64-bit-wide scratchpad after a fixed programmable latency, and returns `dbus_resp_t` handshakes. It sits where the external memory/cache normally attaches to `dreq`/`dresp`. It provides a deterministic, self-contained data memory for core bring-up and for testbenches that need exact stall timing.

## Interface
- `DEPTH_WORDS`, default 1024: scratchpad size in 64-bit words; power of two, at least 2.
- `LATENCY`, default 2: wait cycles between request acceptance and `data_ok`; range 0..15.
- `clk  in  1`: clock; all state updates on its rising edge.
- `reset  in  1`: reset is synchronous and active-low (0 = reset), sampled on `clk`.
- `dreq  in  dbus_req_t`: request, with fields `valid`, `addr`[63:0], `size` (msize_t), `strobe`[7:0] and `data`[63:0]. `strobe != 0` is a store; `strobe == 0` is a load.
- `dresp  out  dbus_resp_t`: response, with fields `addr_ok`, `data_ok` and `data`[63:0].
- `err  out  1`: sticky access-error flag. It is tied to 0 unless the error-checking feature is compiled in.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE.** If `dreq.valid`, latch `addr`, `size`, `strobe` and `data`.
  - Load `cnt` with `LATENCY`.
  - Go to RESP if `LATENCY == 0`, otherwise to WAIT.
- **WAIT.** Decrement `cnt` each cycle. When `cnt == 1` and `dreq.valid` is still high, go to RESP.
- **Abort.** If `dreq.valid` drops in WAIT, return to IDLE with no write and no response.
- **Entering RESP (the same edge that commits the access).**
  - Word index is latched `addr[$clog2(DEPTH_WORDS)+2:3]`.
  - Store: write each byte lane `i` where `strobe[i]` is set, taking data from the latched `data` byte `i`. The `dresp.data` register is set to 0.
  - Load: the `dresp.data` register gets the full 64-bit word. Lane extraction is done by the core.
- **RESP.** `addr_ok` and `data_ok` are both 1 for exactly this one cycle. Next state is IDLE unconditionally.
- Request fields that change after acceptance are ignored; the latched copy is used.
- Scratchpad contents are not affected by reset. Simulation initializes all words to 0.

## Timing
- All outputs are registered.
- Reset values: `addr_ok=0`, `data_ok=0`, `data=0`, `err=0`, state IDLE, `cnt=0`.
- Request accepted in IDLE at cycle T gives `data_ok=1` in cycle T+LATENCY+1.
- Back-to-back: IDLE re-samples `dreq.valid` in cycle T+LATENCY+2, so throughput is one access per LATENCY+2 cycles.
- Outside RESP, `data_ok=0` and `addr_ok=0`. `dresp.data` holds its last value until the next RESP.
- Reset asserted mid-operation (WAIT or RESP): next cycle is IDLE with outputs at reset values; no partial write occurs.
- Load followed by store to the same word: each access sees the state left by the previous committed access. A store in RESP at T is visible to a load accepted at T+1.

## Configuration
- `DBUS_SCRATCHPAD_ERR_EN` defined: each accepted request is checked for two errors.
  - Out of range: `addr >= DEPTH_WORDS*8`.
  - Misaligned: `addr` is not a multiple of the byte count given by `size`.
  - On error, the write is suppressed, the RESP `data` is 0, and `err` is set to 1. `err` stays 1 until reset.
  - The handshake timing is unchanged on error.
- Not defined: no checks. The address wraps modulo `DEPTH_WORDS*8`, byte lanes are taken from `strobe` only, and `err` is constant 0.

## Test plan
- **Reset and store/load, `LATENCY=2`.**
  - Stimulus: hold `reset=0` for 3 cycles, then store `addr=0x10`, `strobe=0xFF`, `data=0x1122334455667788`.
  - Response: `data_ok` in cycle T+3. A load of `0x10` then returns `0x1122334455667788` with `data_ok` at its own T+3.
- **Partial strobe.**
  - Stimulus: store `addr=0x10`, `strobe=0x0F`, `data=0xAAAAAAAA_BBBBBBBB` over the word above.
  - Response: a load returns `0x11223344_BBBBBBBB`.
- **Back-to-back and `LATENCY=0`.**
  - Stimulus: three loads issued immediately after each `data_ok`.
  - Response: `data_ok` pulses exactly every 2 cycles, each 1 cycle wide.
- **Abort.**
  - Stimulus: store accepted, then `valid` dropped during WAIT.
  - Response: no `data_ok`, memory word unchanged, FSM back in IDLE, and the next request is serviced normally.
- **Reset mid-WAIT.**
  - Stimulus: assert `reset=0` during WAIT of a store.
  - Response: all outputs 0 the next cycle and the target word unchanged.
- **With `DBUS_SCRATCHPAD_ERR_EN`.**
  - Stimulus: a load with `size` = 8 bytes at `addr=0x14`.
  - Response: `data=0`, `data_ok` on schedule, `err=1`, and `err` still 1 after a subsequent valid access.
